// File: rtl/tdm_demux41.sv
// Receive end of a 4:1 TDM link: reassembles slots 0..3 of a serial stream into a 4-bit word.
// Each frame is aborted if the frame marker arrives early or if no strobe arrives for TIMEOUT cycles.
module tdm_demux41 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  logic       en,
  input  logic       frame,
  output logic [3:0] q,
  output logic       q_valid,
  output logic [1:0] slot,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  // Expiry is detected on the idle cycle that would bring the count to TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [0:0] state;
  logic [2:0] shadow;
  logic [7:0] tcnt;

  assign busy = (state == COLLECT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      q         <= '0;
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      slot      <= '0;
      shadow    <= '0;
      tcnt      <= '0;
    end else begin
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (en && frame) begin
            shadow[0] <= din;
            slot      <= 2'd1;
            tcnt      <= '0;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (en) begin
            tcnt <= '0;
            if (frame) begin
              // Early marker: drop the partial word and treat this strobe as slot 0.
              frame_err <= 1'b1;
              shadow    <= {2'b00, din};
              slot      <= 2'd1;
            end else begin
              case (slot)
                2'd1: begin
                  shadow[1] <= din;
                  slot      <= 2'd2;
                end
                2'd2: begin
                  shadow[2] <= din;
                  slot      <= 2'd3;
                end
                2'd3: begin
                  q       <= {din, shadow};
                  q_valid <= 1'b1;
                  slot    <= 2'd0;
                  state   <= IDLE;
                end
                default: begin
                  slot  <= 2'd0;
                  state <= IDLE;
                end
              endcase
            end
          end else begin
            if (tcnt != 8'hFF) begin
              tcnt <= tcnt + 8'd1;
            end
            if (tcnt == TMO_LAST) begin
              frame_err <= 1'b1;
              slot      <= 2'd0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          slot  <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/tdm_demux41.md
TDM_DEMUX41 -- requirements
Module: tdm_demux41

Interface
REQ-001 Parameter: TIMEOUT, default 16, max idle clk cycles allowed between slot strobes inside a frame (legal range 2..255).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 din  input  1  serial TDM data bit, sampled only when en=1.
REQ-005 en  input  1  slot strobe; one slot of din per cycle with en=1.
REQ-006 frame  input  1  frame marker; meaningful only with en=1; marks slot 0.
REQ-007 q  output  4  last complete reconstructed word; q[k] = bit from slot k.
REQ-008 q_valid  output  1  one-cycle pulse: q updated this cycle.
REQ-009 slot  output  2  index of next slot expected (0 when idle).
REQ-010 frame_err  output  1  one-cycle pulse: frame aborted.
REQ-011 busy  output  1  high while state = COLLECT.

Function
REQ-012 Block SHALL be the receive end of a 4:1 time-division mux: reassembles 4 serial slots (slot 0..3, in order) into one 4-bit word.
REQ-013 FSM states SHALL be IDLE and COLLECT only.
REQ-014 All outputs SHALL be registered.
REQ-015 IDLE, en=1, frame=1: shadow[0] <= din, slot <= 1, state <= COLLECT, timeout counter cleared.
REQ-016 IDLE, en=1, frame=0: strobe ignored; no state change, no frame_err.
REQ-017 IDLE, en=0: hold all state.
REQ-018 COLLECT, en=1, frame=0, slot=k (k=1,2): shadow[k] <= din, slot <= k+1, timeout counter cleared.
REQ-019 COLLECT, en=1, frame=0, slot=3: q <= {din, shadow[2:0]}, q_valid=1 in the following cycle, slot <= 0, state <= IDLE.
REQ-020 Latency: q and q_valid SHALL be visible the cycle after the edge sampling slot 3.
REQ-021 COLLECT, en=1, frame=1 (early frame marker): frame_err pulse, partial word discarded, q unchanged, restart: shadow[0] <= din, slot <= 1, stay COLLECT.
REQ-022 COLLECT, en=0: timeout counter increments; when it reaches TIMEOUT, frame_err pulse, slot <= 0, state <= IDLE, q unchanged.
REQ-023 Timeout expiry and en=1 SHALL not coincide: en=1 on the expiry cycle is processed normally (strobe wins, counter clears).
REQ-024 q SHALL hold its value indefinitely between complete frames; q_valid and frame_err never high simultaneously.
REQ-025 Back-to-back frames (frame=1 the cycle after slot 3 strobe) SHALL be accepted with no lost cycle.
REQ-026 Timeout counter width SHALL be 8 bits; it SHALL not wrap (saturates, irrelevant once expiry returns to IDLE).

Reset
REQ-027 reset=1 SHALL asynchronously force: state IDLE, q=4'b0000, q_valid=0, frame_err=0, slot=0, busy=0, shadow=0, timeout counter=0.
REQ-028 reset asserted mid-frame SHALL discard the partial word with no frame_err and no q_valid.
REQ-029 First strobe accepted SHALL be the first rising edge after reset deasserts.

Verification
REQ-030 Reset, then en=1 for 4 cycles, frame=1 on first, din=1,0,1,1 -> one cycle later q=4'b1101, q_valid=1 for exactly one cycle, slot=0, busy=0.
REQ-031 Frame din=0,1 (slots 0,1), then en=1 frame=1 din=1, then din=1,1,0 -> frame_err pulse at restart, final q=4'b0111, only one q_valid.
REQ-032 TIMEOUT=16: frame slots 0,1 then en=0 for 16 cycles -> frame_err pulse, busy=0, q keeps prior value; 15-cycle gap then slot 2 -> no error, frame completes.
REQ-033 Two back-to-back frames 4'hA then 4'h5 with no gap -> q_valid pulses on consecutive frame ends, q=4'hA then 4'h5.
REQ-034 en=1 frame=0 strobes in IDLE -> no state change, slot=0, no pulses; reset asserted after slot 2 -> all outputs zero immediately, no pulses.
